axi_decerr_slave: RTL and testbench

- Default responder on the crossbar's slave side.
- Receives every AXI4-Lite transaction for which the address decoder flags a decode error, i.e. the address matches no mapped slave.
- Completes each such transaction with the protocol-correct handshake and a DECERR response, so the master never hangs.
- Also keeps a saturating error count and the address of the most recent unmapped access, for debug visibility.

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/axi_sat_counter.sv | 40 ++++
 rtl/axi_decerr_slave.sv | 144 ++++++++++++++
 tb/tb_axi_decerr_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite crossbar types.
// Response codes and the channel FSM state encodings.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAS_AW,
      W_HAS_W,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

endpackage

// File: rtl/axi_sat_counter.sv
// Saturating up-counter, step 0/1/2.
// Synchronous clear wins over any increment.
module axi_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic [1:0]   inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W+1:0] sum;

   // Next count: clear, else add the step and clamp at all-ones.
   always_comb begin
      sum   = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (sum > {2'b00, {W{1'b1}}}) begin
         cnt_d = '1;
      end else begin
         cnt_d = sum[W-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/axi_decerr_slave.sv
// Default AXI4-Lite responder: answers every access with DECERR
// and keeps a saturating error count plus the last bad address.
module axi_decerr_slave
   import axi_lite_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                CNT_W      = 16,
   parameter logic [DATA_W-1:0] RDATA_FILL = '0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [ADDR_W-1:0]   awaddr_i,
   input  logic                awvalid_i,
   output logic                awready_o,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   input  logic                wvalid_i,
   output logic                wready_o,
   output logic [1:0]          bresp_o,
   output logic                bvalid_o,
   input  logic                bready_i,
   input  logic [ADDR_W-1:0]   araddr_i,
   input  logic                arvalid_i,
   output logic                arready_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [1:0]          rresp_o,
   output logic                rvalid_o,
   input  logic                rready_i,
   output logic [CNT_W-1:0]    err_count_o,
   output logic [ADDR_W-1:0]   last_err_addr_o,
   input  logic                clr_i
);

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic [ADDR_W-1:0] last_err_addr_q, last_err_addr_d;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [1:0] inc;
   logic unused_wdata;

   assign unused_wdata = ^{wdata_i, wstrb_i};

   assign aw_hs = awvalid_i & awready_o;
   assign w_hs  = wvalid_i & wready_o;
   assign b_hs  = bvalid_o & bready_i;
   assign ar_hs = arvalid_i & arready_o;
   assign r_hs  = rvalid_o & rready_i;

   // Write channel: collect AW and W in any order, then hold B.
   always_comb begin
      w_state_d = w_state_q;
      awready_o = 1'b0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            awready_o = 1'b1;
            wready_o  = 1'b1;
            if (aw_hs && w_hs) begin
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               w_state_d = W_HAS_AW;
            end else if (w_hs) begin
               w_state_d = W_HAS_W;
            end
         end
         W_HAS_AW: begin
            wready_o = 1'b1;
            if (w_hs) w_state_d = W_RESP;
         end
         W_HAS_W: begin
            awready_o = 1'b1;
            if (aw_hs) w_state_d = W_RESP;
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (b_hs) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: accept AR, then hold R until taken.
   always_comb begin
      r_state_d = r_state_q;
      arready_o = 1'b0;
      rvalid_o  = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            arready_o = 1'b1;
            if (ar_hs) r_state_d = R_RESP;
         end
         R_RESP: begin
            rvalid_o = 1'b1;
            if (r_hs) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Capture the faulting address; AR wins a same-cycle tie.
   always_comb begin
      last_err_addr_d = last_err_addr_q;
      if (clr_i) begin
         last_err_addr_d = '0;
      end else if (ar_hs) begin
         last_err_addr_d = araddr_i;
      end else if (aw_hs) begin
         last_err_addr_d = awaddr_i;
      end
   end

   // State and debug address registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q       <= W_IDLE;
         r_state_q       <= R_IDLE;
         last_err_addr_q <= '0;
      end else begin
         w_state_q       <= w_state_d;
         r_state_q       <= r_state_d;
         last_err_addr_q <= last_err_addr_d;
      end
   end

   assign inc = {1'b0, b_hs} + {1'b0, r_hs};

   axi_sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .inc_i   (inc),
      .count_o (err_count_o)
   );

   assign bresp_o         = RESP_DECERR;
   assign rresp_o         = RESP_DECERR;
   assign rdata_o         = RDATA_FILL;
   assign last_err_addr_o = last_err_addr_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Randomised and directed bench for axi_decerr_slave against a
// transaction-level model of the DECERR responder.
module tb_axi_decerr_slave;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk;
   logic          rst_ni;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [CW-1:0] err_count;
   logic [AW-1:0] last_addr;
   logic          clr;

   int vectors;
   int miscompares;

   // Model: address/data collected, responses owed, count, address.
   bit            m_aw;
   bit            m_w;
   bit            m_b;
   bit            m_r;
   int            m_cnt;
   logic [AW-1:0] m_addr;

   axi_decerr_slave #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .CNT_W      (CW),
      .RDATA_FILL ('0)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .awaddr_i        (awaddr),
      .awvalid_i       (awvalid),
      .awready_o       (awready),
      .wdata_i         (wdata),
      .wstrb_i         (wstrb),
      .wvalid_i        (wvalid),
      .wready_o        (wready),
      .bresp_o         (bresp),
      .bvalid_o        (bvalid),
      .bready_i        (bready),
      .araddr_i        (araddr),
      .arvalid_i       (arvalid),
      .arready_o       (arready),
      .rdata_o         (rdata),
      .rresp_o         (rresp),
      .rvalid_o        (rvalid),
      .rready_i        (rready),
      .err_count_o     (err_count),
      .last_err_addr_o (last_addr),
      .clr_i           (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_aw   = 0;
      m_w    = 0;
      m_b    = 0;
      m_r    = 0;
      m_cnt  = 0;
      m_addr = '0;
   endtask

   // One clock of the transaction model, using pre-edge state.
   task automatic model_edge();
      bit aw_ok, w_ok, ar_ok, aw_t, w_t, ar_t, b_t, r_t;
      aw_ok = !m_b && !m_aw;
      w_ok  = !m_b && !m_w;
      ar_ok = !m_r;
      aw_t  = awvalid && aw_ok;
      w_t   = wvalid && w_ok;
      ar_t  = arvalid && ar_ok;
      b_t   = m_b && bready;
      r_t   = m_r && rready;
      if (clr) begin
         m_cnt  = 0;
         m_addr = '0;
      end else begin
         m_cnt = m_cnt + int'(b_t) + int'(r_t);
         if (m_cnt > CMAX) m_cnt = CMAX;
         if (ar_t) m_addr = araddr;
         else if (aw_t) m_addr = awaddr;
      end
      if (b_t) begin
         m_b = 0;
      end else begin
         m_aw = m_aw | aw_t;
         m_w  = m_w | w_t;
         if (m_aw && m_w) begin
            m_b  = 1;
            m_aw = 0;
            m_w  = 0;
         end
      end
      if (r_t) m_r = 0;
      else if (ar_t) m_r = 1;
   endtask

   task automatic compare_all();
      chk("awready", 32'(awready), 32'(!m_b && !m_aw));
      chk("wready", 32'(wready), 32'(!m_b && !m_w));
      chk("arready", 32'(arready), 32'(!m_r));
      chk("bvalid", 32'(bvalid), 32'(m_b));
      chk("rvalid", 32'(rvalid), 32'(m_r));
      chk("bresp", 32'(bresp), 32'h3);
      chk("rresp", 32'(rresp), 32'h3);
      chk("rdata", rdata, 32'h0);
      chk("err_count", 32'(err_count), 32'(m_cnt));
      chk("last_addr", last_addr, m_addr);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      awvalid = 0;
      wvalid  = 0;
      arvalid = 0;
      bready  = 0;
      rready  = 0;
      clr     = 0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      awaddr      = '0;
      araddr      = '0;
      wdata       = '0;
      wstrb       = '0;
      idle();
      model_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      compare_all();
      chk("rst_count", 32'(err_count), 32'h0);
      chk("rst_awready", 32'(awready), 32'h1);
      rst_ni = 1'b1;

      // AW and W together.
      awaddr  = 32'h5000_0010;
      awvalid = 1;
      wvalid  = 1;
      tick();
      chk("t1_bvalid", 32'(bvalid), 32'h1);
      chk("t1_addr", last_addr, 32'h5000_0010);
      awvalid = 0;
      wvalid  = 0;
      bready  = 1;
      tick();
      chk("t1_count", 32'(err_count), 32'h1);
      bready = 0;

      // W three cycles before AW, B back-pressured.
      wvalid = 1;
      tick();
      wvalid = 0;
      chk("t2_wready", 32'(wready), 32'h0);
      tick();
      tick();
      awaddr  = 32'h7000_0040;
      awvalid = 1;
      tick();
      awvalid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_bhold", 32'(bvalid), 32'h1);
      end
      bready = 1;
      tick();
      bready = 0;
      tick();
      chk("t2_count", 32'(err_count), 32'h2);
      chk("t2_bdone", 32'(bvalid), 32'h0);

      // Read with rready high.
      araddr  = 32'h0000_1234;
      arvalid = 1;
      rready  = 1;
      tick();
      arvalid = 0;
      chk("t3_rvalid", 32'(rvalid), 32'h1);
      chk("t3_arready", 32'(arready), 32'h0);
      chk("t3_rdata", rdata, 32'h0);
      tick();
      chk("t3_count", 32'(err_count), 32'h3);
      rready = 0;

      // AR and AW in one cycle: AR address is kept.
      awaddr  = 32'hA000_0000;
      araddr  = 32'hB000_0000;
      awvalid = 1;
      arvalid = 1;
      tick();
      chk("t5_addr", last_addr, 32'hB000_0000);
      awvalid = 0;
      arvalid = 0;
      wvalid  = 1;
      tick();
      wvalid = 0;
      bready = 1;
      rready = 1;
      tick();
      chk("t5_count", 32'(err_count), 32'h5);

      // Nine reads bring the count to 14.
      arvalid = 1;
      repeat (18) tick();
      idle();
      chk("t4_14", 32'(err_count), 32'd14);
      awvalid = 1;
      wvalid  = 1;
      arvalid = 1;
      tick();
      idle();
      bready = 1;
      rready = 1;
      tick();
      chk("t4_sat", 32'(err_count), 32'd15);
      idle();
      arvalid = 1;
      tick();
      arvalid = 0;
      rready  = 1;
      tick();
      chk("t4_hold", 32'(err_count), 32'd15);
      idle();

      // Clear beats a same-cycle capture.
      araddr  = 32'hDEAD_0000;
      arvalid = 1;
      clr     = 1;
      tick();
      chk("clr_count", 32'(err_count), 32'h0);
      chk("clr_addr", last_addr, 32'h0);
      idle();
      rready = 1;
      tick();
      idle();

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         awaddr  = $urandom;
         araddr  = $urandom;
         wdata   = $urandom;
         wstrb   = 4'($urandom_range(0, 15));
         awvalid = 1'($urandom_range(0, 1));
         wvalid  = 1'($urandom_range(0, 1));
         arvalid = 1'($urandom_range(0, 1));
         bready  = 1'($urandom_range(0, 1));
         rready  = 1'($urandom_range(0, 1));
         clr     = ($urandom_range(0, 31) == 0);
         tick();
      end

      // Reset with both responses pending.
      idle();
      awvalid = 1;
      wvalid  = 1;
      arvalid = 1;
      tick();
      idle();
      chk("rs_bvalid_pre", 32'(bvalid), 32'h1);
      chk("rs_rvalid_pre", 32'(rvalid), 32'h1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rs_bvalid", 32'(bvalid), 32'h0);
      chk("rs_rvalid", 32'(rvalid), 32'h0);
      chk("rs_count", 32'(err_count), 32'h0);
      model_reset();
      @(negedge clk);
      compare_all();
      rst_ni = 1'b1;
      bready = 1;
      rready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rs_nostale_b", 32'(bvalid), 32'h0);
         chk("rs_nostale_r", 32'(rvalid), 32'h0);
      end
      chk("rs_ready", 32'({awready, wready, arready}), 32'h7);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
